// File: rtl/alu_control_seq_if.sv
// Handshake bundle between decode, the ALU control stage and EX.
// master = decode/EX side, slave = alu_control_seq.
interface alu_control_seq_if #(
    parameter int OP_W    = 4,
    parameter int FUNCT_W = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         ALUOp;
    logic [FUNCT_W-1:0] funct;
    logic               out_valid;
    logic               out_ready;
    logic [OP_W-1:0]    Op;
    logic               md_busy;
    logic               illegal;
    logic               var_shift;

    modport master (
        output in_valid, ALUOp, funct, out_ready,
        input  in_ready, out_valid, Op, md_busy, illegal, var_shift
    );

    modport slave (
        input  in_valid, ALUOp, funct, out_ready,
        output in_ready, out_valid, Op, md_busy, illegal, var_shift
    );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control stage: decodes {ALUOp, funct} into Op behind a one-entry
// valid/ready register, holding off decode while a mul/div runs. Optional: ALU_CTRL_SHIFTV_EN (sllv/srlv).
module alu_control_seq #(
    parameter int OP_W          = 4,
    parameter int FUNCT_W       = 6,
    parameter int MULDIV_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    alu_control_seq_if.slave bus
);
    localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, MD, HOLD} state_e;

    typedef struct packed {
        logic [3:0] code;
        logic       illegal;
        logic       var_shift;
        logic       muldiv;
    } dec_t;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OP_W-1:0]  op_q;
    logic             illegal_q;
    logic             var_shift_q;
    logic             out_valid_q;
    logic             md_busy_q;
    logic             in_ready;
    logic             accept;
    dec_t             dec;

    function automatic dec_t decode(input logic [1:0] aluop, input logic [FUNCT_W-1:0] f);
        dec_t d;
        d = '{code: 4'b0010, illegal: 1'b0, var_shift: 1'b0, muldiv: 1'b0};
        case (aluop)
            2'b00: d.code = 4'b0010;
            2'b01: d.code = 4'b0110;
            2'b11: d.code = 4'b0001;
            default: begin
                // Any set bit above the 6-bit funct field makes the op undecodable.
                if ((f >> 6) != '0) begin
                    d.illegal = 1'b1;
                end else begin
                    case (f[5:0])
                        6'd36: d.code = 4'b0000;
                        6'd37: d.code = 4'b0001;
                        6'd32: d.code = 4'b0010;
                        6'd34: d.code = 4'b0110;
                        6'd42: d.code = 4'b0111;
                        6'd39: d.code = 4'b1100;
                        6'd0:  d.code = 4'b1110;
                        6'd2:  d.code = 4'b1111;
                        6'd24: begin d.code = 4'b1000; d.muldiv = 1'b1; end
                        6'd25: begin d.code = 4'b1001; d.muldiv = 1'b1; end
                        6'd26: begin d.code = 4'b1010; d.muldiv = 1'b1; end
                        6'd27: begin d.code = 4'b1011; d.muldiv = 1'b1; end
`ifdef ALU_CTRL_SHIFTV_EN
                        6'd4:  begin d.code = 4'b1110; d.var_shift = 1'b1; end
                        6'd6:  begin d.code = 4'b1111; d.var_shift = 1'b1; end
`endif
                        default: d.illegal = 1'b1;
                    endcase
                end
            end
        endcase
        return d;
    endfunction

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            HOLD:    in_ready = bus.out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = bus.in_valid && in_ready;
    assign dec    = decode(bus.ALUOp, bus.funct);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            illegal_q   <= 1'b0;
            var_shift_q <= 1'b0;
            out_valid_q <= 1'b0;
            md_busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        op_q        <= OP_W'(dec.code);
                        illegal_q   <= dec.illegal;
                        var_shift_q <= dec.var_shift;
                        if (dec.muldiv) begin
                            // Loaded with the full cycle count so Op appears MULDIV_CYCLES+1 edges after accept.
                            state_q     <= MD;
                            cnt_q       <= CNT_W'(MULDIV_CYCLES);
                            md_busy_q   <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= HOLD;
                            out_valid_q <= 1'b1;
                        end
                    end else if (state_q == HOLD && bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                MD: begin
                    if (cnt_q == '0) begin
                        state_q     <= HOLD;
                        md_busy_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.Op        = op_q;
    assign bus.md_busy   = md_busy_q;
    assign bus.illegal   = illegal_q;
    assign bus.var_shift = var_shift_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: randomized and directed ops against a table-driven model.
module tb_alu_control_seq;
    localparam int OP_W = 4;
    localparam int FUNCT_W = 6;
    localparam int M = 4;

    localparam int         FL[12] = '{36, 37, 32, 34, 42, 39, 0, 2, 24, 25, 26, 27};
    localparam logic [3:0] OL[12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                                      4'b1110, 4'b1111, 4'b1000, 4'b1001, 4'b1010, 4'b1011};

    typedef struct {
        logic [3:0] op;
        logic       ill;
        logic       vs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rnd_or = 1'b0;
    logic or_fix = 1'b1;
    logic or_rand = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    alu_control_seq_if #(.OP_W(OP_W), .FUNCT_W(FUNCT_W)) bus ();

    alu_control_seq #(.OP_W(OP_W), .FUNCT_W(FUNCT_W), .MULDIV_CYCLES(M)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.out_ready = rnd_or ? or_rand : or_fix;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        or_rand <= ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic exp_t model(input logic [1:0] a, input logic [5:0] f);
        exp_t e;
        e.op = 4'b0010; e.ill = 1'b0; e.vs = 1'b0;
        if (a == 2'b01) e.op = 4'b0110;
        else if (a == 2'b11) e.op = 4'b0001;
        else if (a == 2'b10) begin
            e.ill = 1'b1;
            for (int i = 0; i < 12; i++)
                if (int'(f) == FL[i]) begin e.op = OL[i]; e.ill = 1'b0; end
`ifdef ALU_CTRL_SHIFTV_EN
            if (f == 6'd4) begin e.op = 4'b1110; e.vs = 1'b1; e.ill = 1'b0; end
            if (f == 6'd6) begin e.op = 4'b1111; e.vs = 1'b1; e.ill = 1'b0; end
`endif
        end
        return e;
    endfunction

    task automatic send(input logic [1:0] a, input logic [5:0] f, output int acc);
        bus.in_valid = 1'b1; bus.ALUOp = a; bus.funct = f; acc = -1;
        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(a, f));
                acc = cyc;
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.md_busy) check("busy_blocks_in_ready", bus.in_ready, 1'b0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("Op", bus.Op, e.op);
                    check("illegal", bus.illegal, e.ill);
                    check("var_shift", bus.var_shift, e.vs);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, first;
        logic [5:0] sweep[8];
        bus.in_valid = 1'b0; bus.ALUOp = 2'b00; bus.funct = '0;
        sweep = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd39, 6'd0, 6'd2};
        #3;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_Op", bus.Op, 4'd0);
        #9 rst = 1'b0;
        @(negedge clk);
        check("rst_md_busy", bus.md_busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_illegal", bus.illegal, 1'b0);
        check("rst_var_shift", bus.var_shift, 1'b0);
        @(posedge clk); #1;

        // Back-to-back funct sweep, one op per cycle.
        first = 0;
        for (int i = 0; i < 8; i++) begin
            send(2'b10, sweep[i], acc);
            if (i == 0) first = acc;
            else check("sweep_throughput", acc - first, i);
        end
        repeat (2) @(posedge clk); #1;

        // Mul/div latency.
        send(2'b10, 6'd26, acc);
        for (int k = 1; k <= M + 1; k++) begin
            @(posedge clk); #1;
            if (k <= M) begin
                check("md_busy_during", bus.md_busy, 1'b1);
                check("md_in_ready", bus.in_ready, 1'b0);
                check("md_out_valid_low", bus.out_valid, 1'b0);
            end else begin
                check("md_out_valid_rise", bus.out_valid, 1'b1);
                check("md_busy_done", bus.md_busy, 1'b0);
                check("md_Op", bus.Op, 4'b1010);
            end
        end
        repeat (2) @(posedge clk); #1;

        // Reset in the middle of a mult.
        send(2'b10, 6'd24, acc);
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_busy", bus.md_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("midmd_out_valid", bus.out_valid, 1'b0);
        check("midmd_md_busy", bus.md_busy, 1'b0);
        check("midmd_Op", bus.Op, 4'd0);
        check("midmd_in_ready", bus.in_ready, 1'b1);
        exp_q.delete();
        #1 rst = 1'b0;
        for (int k = 0; k < M + 2; k++) begin
            @(negedge clk);
            check("dropped_md_no_output", bus.out_valid, 1'b0);
        end
        @(posedge clk); #1;

        // Backpressure: add held, sub waits.
        or_fix = 1'b0;
        send(2'b00, 6'd0, acc);
        fork
            send(2'b01, 6'd0, acc);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("bp_Op_stable", bus.Op, 4'b0010);
                    check("bp_in_ready", bus.in_ready, 1'b0);
                    check("bp_out_valid", bus.out_valid, 1'b1);
                end
                @(posedge clk); #1;
                or_fix = 1'b1;
            end
        join

        // Illegal funct followed by ori; variable shifts.
        send(2'b10, 6'd5, acc);
        send(2'b11, 6'd5, acc);
        send(2'b10, 6'd4, acc);
        send(2'b10, 6'd6, acc);
        repeat (2) @(posedge clk); #1;

        // Random traffic with random EX backpressure.
        rnd_or = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [1:0] a;
            logic [5:0] f;
            a = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) f = 6'(FL[$urandom_range(0, 11)]);
            else f = 6'($urandom_range(0, 63));
            send(a, f, acc);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rnd_or = 1'b0;
        or_fix = 1'b1;
        for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
